// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: arbitrates I-cache and D-cache block requests
// onto the shared 32-bit iomem port, four beats per block.
module anabellek_denetleyici #(
    parameter int OBEK_KELIME = 4,
    parameter int ADRES_BIT   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      bbellek_istek_i,
    input  logic [ADRES_BIT-1:0]      bbellek_adres_i,
    input  logic                      vbellek_istek_i,
    input  logic                      vbellek_yaz_i,
    input  logic [ADRES_BIT-1:0]      vbellek_adres_i,
    input  logic [32*OBEK_KELIME-1:0] vbellek_obek_i,
    input  logic                      iomem_ready_i,
    input  logic [31:0]               iomem_rdata_i,
    output logic                      iomem_valid_o,
    output logic [ADRES_BIT-1:0]      iomem_addr_o,
    output logic [31:0]               iomem_wdata_o,
    output logic [3:0]                iomem_wstrb_o,
    output logic                      musait_o,
    output logic [32*OBEK_KELIME-1:0] obek_o,
    output logic                      bbellek_hazir_o,
    output logic                      vbellek_hazir_o
);

    localparam int SB = $clog2(OBEK_KELIME);
    localparam logic [SB-1:0] SON_KELIME = SB'(OBEK_KELIME - 1);

    typedef enum logic [1:0] {
        BOSTA,
        BEKLE,
        ARA,
        BITTI
    } durum_t;

    durum_t                    r_durum;
    durum_t                    w_sonraki;
    logic                      r_sahip;
    logic                      r_yaz;
    logic                      r_son;
    logic [ADRES_BIT-1:0]      r_taban;
    logic [32*OBEK_KELIME-1:0] r_veri;
    logic [32*OBEK_KELIME-1:0] r_obek;
    logic [SB-1:0]             r_sayac;

    logic                      w_istek;
    logic                      w_sec_v;
    logic [ADRES_BIT-1:0]      w_adres;
    logic [ADRES_BIT-1:0]      w_ofs;
    logic [31:0]               w_kelime;

    // r_son = 1 when the data cache was granted last; a tie goes to the other side
    assign w_istek  = bbellek_istek_i | vbellek_istek_i;
    assign w_sec_v  = vbellek_istek_i & (~bbellek_istek_i | ~r_son);
    assign w_adres  = w_sec_v ? vbellek_adres_i : bbellek_adres_i;
    assign w_ofs    = ADRES_BIT'({r_sayac, 2'b00});
    assign w_kelime = r_veri[{r_sayac, 5'b00000} +: 32];
    assign obek_o   = r_obek;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum <= BOSTA;
            r_sahip <= 1'b0;
            r_yaz   <= 1'b0;
            r_son   <= 1'b0;
            r_taban <= '0;
            r_veri  <= '0;
            r_obek  <= '0;
            r_sayac <= '0;
        end else begin
            r_durum <= w_sonraki;
            unique case (r_durum)
                BOSTA: begin
                    if (w_istek) begin
                        r_sahip <= w_sec_v;
                        r_yaz   <= w_sec_v & vbellek_yaz_i;
                        r_taban <= w_adres & ~ADRES_BIT'(15);
                        r_veri  <= vbellek_obek_i;
                        r_sayac <= '0;
                    end
                end
                BEKLE: begin
                    if (iomem_ready_i) begin
                        if (!r_yaz) begin
                            r_obek[{r_sayac, 5'b00000} +: 32] <= iomem_rdata_i;
                        end
                        if (r_sayac != SON_KELIME) begin
                            r_sayac <= r_sayac + 1'b1;
                        end
                    end
                end
                ARA: begin
                end
                BITTI: begin
                    r_son <= r_sahip;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_sonraki       = r_durum;
        iomem_valid_o   = 1'b0;
        iomem_addr_o    = '0;
        iomem_wdata_o   = '0;
        iomem_wstrb_o   = 4'h0;
        musait_o        = 1'b0;
        bbellek_hazir_o = 1'b0;
        vbellek_hazir_o = 1'b0;
        unique case (r_durum)
            BOSTA: begin
                musait_o = 1'b1;
                if (w_istek) begin
                    w_sonraki = BEKLE;
                end
            end
            BEKLE: begin
                iomem_valid_o = 1'b1;
                iomem_addr_o  = r_taban + w_ofs;
                if (r_yaz) begin
                    iomem_wstrb_o = 4'hF;
                    iomem_wdata_o = w_kelime;
                end
                if (iomem_ready_i) begin
                    w_sonraki = (r_sayac == SON_KELIME) ? BITTI : ARA;
                end
            end
            ARA: begin
                w_sonraki = BEKLE;
            end
            BITTI: begin
                bbellek_hazir_o = ~r_sahip;
                vbellek_hazir_o = r_sahip;
                w_sonraki       = BOSTA;
            end
            default: begin
                w_sonraki = BOSTA;
            end
        endcase
    end

endmodule
